// File: rtl/param_fifo.sv
// param_fifo -- single-clock synchronous FIFO with configurable width/depth,
// registered or first-word-fall-through read port, threshold flags and
// sticky error flags.
//
// Parameters
//   WIDTH     data word width (>= 1)
//   DEPTH     storage words (power of two, >= 4)
//   AF_LEVEL  almost_full when level >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when level <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0: registered read, 1: first-word-fall-through
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   write_en      write request, accepted when !full
//   data_in       write data
//   read_en       read request, accepted when !empty
//   clear_err     clears overflow/underflow (a new error wins)
//   data_out      read data
//   data_valid    data_out qualifier
//   full, empty, almost_full, almost_empty   decoded from registered level
//   level         words currently stored
//   overflow      sticky: a write was refused
//   underflow     sticky: a read was refused

module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_en,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags depend only on the registered level, never on this cycle's requests.
  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  // Pointers carry one extra bit so they wrap modulo 2*DEPTH; level is kept
  // as its own register and always equals wr_ptr - rd_ptr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    end
  end

  // Storage is deliberately not reset; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // A same-cycle error condition takes priority over clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full)  overflow <= 1'b1;
      else if (clear_err)    overflow <= 1'b0;
      if (read_en && empty)  underflow <= 1'b1;
      else if (clear_err)    underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always visible; a write into an empty FIFO shows up
      // right after its write edge because level leaves zero at that edge.
      assign data_out   = mem[rd_ptr[AW-1:0]];
      assign data_valid = !empty;
    end else begin : g_reg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_out   <= '0;
          data_valid <= 1'b0;
        end else begin
          data_valid <= rd_acc;
          if (rd_acc) data_out <= mem[rd_ptr[AW-1:0]];
        end
      end
    end
  endgenerate

endmodule
